// File: rtl/trap_seq_u_pkg.sv
// Shared constants for the machine-mode trap sequencer.
// Holds the exception cause encodings, the CSR addresses and the mcause codes,
// plus small helpers that turn a latched cause or a raw address into write data.
package trap_seq_u_pkg;

  // Exception cause encodings driven by the exception controller
  localparam logic [1:0] CAUSE_NOT_EXCEPTION       = 2'd0;
  localparam logic [1:0] CAUSE_I_ADDR_MISALIGNMENT = 2'd1;
  localparam logic [1:0] CAUSE_ECALL               = 2'd2;

  // CSR addresses touched by the sequencer
  localparam logic [11:0] MEPC_ADDR    = 12'h341;
  localparam logic [11:0] MCAUSE_ADDR  = 12'h342;
  localparam logic [11:0] MTVAL_ADDR   = 12'h343;
  localparam logic [11:0] MSTATUS_ADDR = 12'h300;

  // mcause values written for each supported cause
  localparam logic [31:0] MCAUSE_CODE_I_ADDR = 32'd0;
  localparam logic [31:0] MCAUSE_CODE_ECALL  = 32'd11;

  // Map a latched cause onto its mcause value; anything unexpected is an ECALL
  function automatic logic [31:0] mcause_code(input logic [1:0] cause);
    logic [31:0] code;
    case (cause)
      CAUSE_I_ADDR_MISALIGNMENT: code = MCAUSE_CODE_I_ADDR;
      CAUSE_ECALL:               code = MCAUSE_CODE_ECALL;
      default:                   code = MCAUSE_CODE_ECALL;
    endcase
    return code;
  endfunction

  // Force an address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_seq_u.sv
// Machine-mode trap entry / MRET return sequencer.
// Trap: latch cause/pc/tval, write mepc, mcause, mtval through the single CSR
// port, then redirect fetch to mtvec (direct mode). MRET: redirect fetch to mepc.
// Optional macro TRAP_SEQ_MSTATUS_EN adds an mstatus update on both paths.
// All outputs are registered: they are decoded from the state being entered so
// that they line up exactly with the state register.
module trap_seq_u
  import trap_seq_u_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_raised,
  input  logic [1:0]  e_cause,
  input  logic [31:0] e_pc,
  input  logic [31:0] e_tval,
  input  logic        is_mret,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] mstatus,
  output logic        stall,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    W_MEPC      = 3'd1,
    W_MCAUSE    = 3'd2,
    W_MTVAL     = 3'd3,
    T_REDIR     = 3'd4,
`ifdef TRAP_SEQ_MSTATUS_EN
    W_MSTATUS   = 3'd6,
    W_MSTATUS_R = 3'd7,
`endif
    R_REDIR     = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cause, cause_nxt;
  logic [29:0] pc_word, pc_word_nxt;
  logic [31:0] tval, tval_nxt;

  logic        stall_nxt, flush_nxt, redirect_nxt, csr_we_nxt, busy_nxt;
  logic [31:0] redirect_pc_nxt, csr_wdata_nxt;
  logic [11:0] csr_waddr_nxt;

  // Only the word part of the PCs matter; the low bits are masked away.
`ifdef TRAP_SEQ_MSTATUS_EN
  logic unused_bits;
  assign unused_bits = ^{e_pc[1:0], mtvec[1:0], mepc[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{e_pc[1:0], mtvec[1:0], mepc[1:0], mstatus};
`endif

  // Next-state and trap-latch logic; requests are only accepted in IDLE
  always_comb begin
    state_nxt   = state;
    cause_nxt   = cause;
    pc_word_nxt = pc_word;
    tval_nxt    = tval;
    case (state)
      IDLE: begin
        if (e_raised) begin
          cause_nxt   = e_cause;
          pc_word_nxt = e_pc[31:2];
          tval_nxt    = e_tval;
          state_nxt   = W_MEPC;
        end else if (is_mret) begin
`ifdef TRAP_SEQ_MSTATUS_EN
          state_nxt = W_MSTATUS_R;
`else
          state_nxt = R_REDIR;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      W_MEPC:   state_nxt = W_MCAUSE;
      W_MCAUSE: state_nxt = W_MTVAL;
`ifdef TRAP_SEQ_MSTATUS_EN
      W_MTVAL:     state_nxt = W_MSTATUS;
      W_MSTATUS:   state_nxt = T_REDIR;
      W_MSTATUS_R: state_nxt = R_REDIR;
`else
      W_MTVAL:     state_nxt = T_REDIR;
`endif
      T_REDIR:  state_nxt = IDLE;
      R_REDIR:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Moore output decode of the state about to be entered
  always_comb begin
    busy_nxt        = (state_nxt != IDLE);
    stall_nxt       = busy_nxt;
    flush_nxt       = busy_nxt;
    redirect_nxt    = 1'b0;
    redirect_pc_nxt = 32'd0;
    csr_we_nxt      = 1'b0;
    csr_waddr_nxt   = 12'd0;
    csr_wdata_nxt   = 32'd0;
    case (state_nxt)
      W_MEPC: begin
        csr_we_nxt    = 1'b1;
        csr_waddr_nxt = MEPC_ADDR;
        csr_wdata_nxt = {pc_word_nxt, 2'b00};
      end
      W_MCAUSE: begin
        csr_we_nxt    = 1'b1;
        csr_waddr_nxt = MCAUSE_ADDR;
        csr_wdata_nxt = mcause_code(cause_nxt);
      end
      W_MTVAL: begin
        csr_we_nxt    = 1'b1;
        csr_waddr_nxt = MTVAL_ADDR;
        csr_wdata_nxt = tval_nxt;
      end
`ifdef TRAP_SEQ_MSTATUS_EN
      W_MSTATUS: begin
        // MPIE <= MIE, MIE <= 0, MPP <= machine
        csr_we_nxt    = 1'b1;
        csr_waddr_nxt = MSTATUS_ADDR;
        csr_wdata_nxt = {mstatus[31:13], 2'b11, mstatus[10:8], mstatus[3],
                         mstatus[6:4], 1'b0, mstatus[2:0]};
      end
      W_MSTATUS_R: begin
        // MIE <= MPIE, MPIE <= 1
        csr_we_nxt    = 1'b1;
        csr_waddr_nxt = MSTATUS_ADDR;
        csr_wdata_nxt = {mstatus[31:8], 1'b1, mstatus[6:4], mstatus[7],
                         mstatus[2:0]};
      end
`endif
      T_REDIR: begin
        redirect_nxt    = 1'b1;
        redirect_pc_nxt = word_align(mtvec);
      end
      R_REDIR: begin
        redirect_nxt    = 1'b1;
        redirect_pc_nxt = word_align(mepc);
      end
      default: begin
        redirect_nxt = 1'b0;
      end
    endcase
  end

  // State, trap latches and registered outputs; reset clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cause       <= 2'd0;
      pc_word     <= 30'd0;
      tval        <= 32'd0;
      stall       <= 1'b0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
      csr_we      <= 1'b0;
      csr_waddr   <= 12'd0;
      csr_wdata   <= 32'd0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cause       <= cause_nxt;
      pc_word     <= pc_word_nxt;
      tval        <= tval_nxt;
      stall       <= stall_nxt;
      flush       <= flush_nxt;
      redirect    <= redirect_nxt;
      redirect_pc <= redirect_pc_nxt;
      csr_we      <= csr_we_nxt;
      csr_waddr   <= csr_waddr_nxt;
      csr_wdata   <= csr_wdata_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_trap_seq_u.sv
// Self-checking bench for trap_seq_u: directed scenarios followed by random
// traffic, compared cycle by cycle against a queue of expected output cycles.
module tb_trap_seq_u;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e_raised = 1'b0;
  logic [1:0]  e_cause = 2'd0;
  logic [31:0] e_pc = 32'd0, e_tval = 32'd0;
  logic        is_mret = 1'b0;
  logic [31:0] mtvec = 32'd0, mepc = 32'd0, mstatus = 32'd0;
  logic        stall, flush, redirect, csr_we, busy;
  logic [31:0] redirect_pc, csr_wdata;
  logic [11:0] csr_waddr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  logic cur_busy = 1'b0;

  trap_seq_u dut (
    .clk(clk), .rst_n(rst_n), .e_raised(e_raised), .e_cause(e_cause),
    .e_pc(e_pc), .e_tval(e_tval), .is_mret(is_mret), .mtvec(mtvec),
    .mepc(mepc), .mstatus(mstatus), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t busy_cycle();
    exp_t e = '0;
    e.stall = 1'b1; e.flush = 1'b1; e.busy = 1'b1;
    return e;
  endfunction

  function automatic exp_t csr_cycle(input logic [11:0] a, input logic [31:0] d);
    exp_t e = busy_cycle();
    e.we = 1'b1; e.waddr = a; e.wdata = d;
    return e;
  endfunction

  function automatic exp_t redir_cycle(input logic [31:0] target);
    exp_t e = busy_cycle();
    e.redirect = 1'b1; e.rpc = target & 32'hFFFF_FFFC;
    return e;
  endfunction

  // Reference: what the pipeline should see for an accepted trap
  task automatic model_trap();
    logic [31:0] ms;
    exp_q.push_back(csr_cycle(12'h341, e_pc & 32'hFFFF_FFFC));
    exp_q.push_back(csr_cycle(12'h342, (e_cause == 2'd1) ? 32'd0 : 32'd11));
    exp_q.push_back(csr_cycle(12'h343, e_tval));
`ifdef TRAP_SEQ_MSTATUS_EN
    ms = mstatus;
    ms[7] = mstatus[3];
    ms[3] = 1'b0;
    ms[12:11] = 2'b11;
    exp_q.push_back(csr_cycle(12'h300, ms));
`else
    ms = 32'd0;
`endif
    exp_q.push_back(redir_cycle(mtvec + ms[0 +: 32] * 32'd0));
  endtask

  // Reference: what the pipeline should see for an accepted MRET
  task automatic model_mret();
`ifdef TRAP_SEQ_MSTATUS_EN
    logic [31:0] ms;
    ms = mstatus;
    ms[3] = mstatus[7];
    ms[7] = 1'b1;
    exp_q.push_back(csr_cycle(12'h300, ms));
`endif
    exp_q.push_back(redir_cycle(mepc));
  endtask

  task automatic compare_outputs(input string ctx);
    exp_t e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_t'('0);
    check_eq({ctx, ".stall"},       {31'd0, stall},     {31'd0, e.stall});
    check_eq({ctx, ".flush"},       {31'd0, flush},     {31'd0, e.flush});
    check_eq({ctx, ".redirect"},    {31'd0, redirect},  {31'd0, e.redirect});
    check_eq({ctx, ".redirect_pc"}, redirect_pc,        e.rpc);
    check_eq({ctx, ".csr_we"},      {31'd0, csr_we},    {31'd0, e.we});
    check_eq({ctx, ".csr_waddr"},   {20'd0, csr_waddr}, {20'd0, e.waddr});
    check_eq({ctx, ".csr_wdata"},   csr_wdata,          e.wdata);
    check_eq({ctx, ".busy"},        {31'd0, busy},      {31'd0, e.busy});
    cur_busy = e.busy;
  endtask

  // Apply one cycle of stimulus (inputs already set), update model, check
  task automatic run_cycle(input string ctx);
    if (!cur_busy) begin
      if (e_raised) model_trap();
      else if (is_mret) model_mret();
    end
    @(negedge clk);
    compare_outputs(ctx);
  endtask

  task automatic idle_inputs();
    e_raised = 1'b0; is_mret = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    compare_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    compare_outputs("post_reset");

    // ECALL trap
    mtvec = 32'h0000_8001; mepc = 32'h0001_0044; mstatus = 32'h0000_0008;
    e_raised = 1'b1; e_cause = 2'd2; e_pc = 32'h0001_0040; e_tval = 32'd0;
    run_cycle("ecall");
    idle_inputs();
    repeat (6) run_cycle("ecall");

    // Misaligned fetch trap
    e_raised = 1'b1; e_cause = 2'd1; e_pc = 32'h0001_0042; e_tval = 32'h0001_0042;
    run_cycle("misalign");
    idle_inputs();
    repeat (6) run_cycle("misalign");

    // MRET
    mstatus = 32'h0000_1880;
    is_mret = 1'b1;
    run_cycle("mret");
    idle_inputs();
    repeat (3) run_cycle("mret");

    // Trap and MRET together, then a second trap while busy
    mstatus = 32'h0000_0008;
    e_raised = 1'b1; is_mret = 1'b1; e_cause = 2'd2; e_pc = 32'h0000_2000; e_tval = 32'h55;
    run_cycle("both");
    is_mret = 1'b0; e_cause = 2'd1; e_pc = 32'h0000_3000; e_tval = 32'h66;
    run_cycle("busy_req");
    idle_inputs();
    repeat (6) run_cycle("both");

    // Asynchronous reset in the middle of the mcause write
    e_raised = 1'b1; e_cause = 2'd2; e_pc = 32'h0000_4000; e_tval = 32'd7;
    run_cycle("rst_mid");
    idle_inputs();
    run_cycle("rst_mid");
    #1 rst_n = 1'b0;
    #1;
    exp_q.delete();
    compare_outputs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle("rst_release");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      e_raised = ($urandom_range(0, 9) < 3);
      is_mret  = ($urandom_range(0, 9) < 2);
      e_cause  = 2'($urandom_range(0, 3));
      e_pc     = $urandom;
      e_tval   = $urandom;
      if (!cur_busy) begin
        mtvec   = $urandom;
        mepc    = $urandom;
        mstatus = $urandom;
      end
      run_cycle("rand");
    end
    idle_inputs();
    repeat (8) run_cycle("drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
